fpu_exception_handler: RTL and testbench

FPU_EXCEPTION_HANDLER -- requirements
Module: fpu_exception_handler

---
 rtl/fpu_pack.sv | 44 ++++
 rtl/fp8_classify.sv | 25 ++
 rtl/fpu_exception_handler.sv | 180 ++++++++++++++++++
 tb/tb_fpu_exception_handler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pack.sv
// Shared FP8 constants, opcodes and small helpers for the exception handler.
package fpu_pack;

    localparam int FP_W   = 8;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 3;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } fp_op_e;

    localparam logic [FP_W-1:0] _PLUS_INF   = 8'h78;
    localparam logic [FP_W-1:0] _MINUS_INF  = 8'hF8;
    localparam logic [FP_W-1:0] _CANON_NAN  = 8'h7C;
    localparam logic [FP_W-1:0] _PLUS_ZERO  = 8'h00;
    localparam logic [FP_W-1:0] _MINUS_ZERO = 8'h80;

    // Outcome of the special-case evaluation for one request.
    typedef struct packed {
        logic [FP_W-1:0] result;
        logic            special;
        logic            invalid;
    } special_res_t;

    function automatic logic [FP_W-1:0] signed_inf(input logic s);
        return s ? _MINUS_INF : _PLUS_INF;
    endfunction

    function automatic logic [FP_W-1:0] signed_zero(input logic s);
        return s ? _MINUS_ZERO : _PLUS_ZERO;
    endfunction

    function automatic logic [FP_W-1:0] negate(input logic [FP_W-1:0] v);
        return {~v[FP_W-1], v[FP_W-2:0]};
    endfunction

    function automatic logic is_inf_code(input logic [FP_W-1:0] v);
        return (v == _PLUS_INF) || (v == _MINUS_INF);
    endfunction

endpackage

// File: rtl/fp8_classify.sv
// Combinational classifier for one FP8 operand (1 sign / 4 exp / 3 mantissa).
module fp8_classify
    import fpu_pack::*;
(
    input  logic [FP_W-1:0] op,
    output logic            is_nan,
    output logic            is_inf,
    output logic            is_zero,
    output logic            sign
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;

    // Split fields and decode the three special encodings.
    always_comb begin
        exp_f   = op[FP_W-2 -: EXP_W];
        mant_f  = op[MANT_W-1:0];
        sign    = op[FP_W-1];
        is_nan  = (&exp_f) && (|mant_f);
        is_inf  = (&exp_f) && !(|mant_f);
        is_zero = !(|exp_f) && !(|mant_f);
    end

endmodule

// File: rtl/fpu_exception_handler.sv
// FP8 special-case / exception front end: resolves NaN, inf and zero cases
// into a registered result with valid/ready handshake, and keeps sticky
// invalid/inf flags plus a saturating invalid-event counter.
module fpu_exception_handler
    import fpu_pack::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       FP_OPERATION,
    input  logic [7:0]       OP_A,
    input  logic [7:0]       OP_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [7:0]       RESULT,
    output logic             RESULT_SPECIAL,
    output logic             EXC_INVALID,
    output logic             STICKY_INVALID,
    output logic             STICKY_INF,
    output logic [CNT_W-1:0] EXC_COUNT,
    input  logic             CLR_STICKY
);

    logic a_nan, a_inf, a_zero, a_sign;
    logic b_nan, b_inf, b_zero, b_sign;

    fp8_classify u_class_a (
        .op      (OP_A),
        .is_nan  (a_nan),
        .is_inf  (a_inf),
        .is_zero (a_zero),
        .sign    (a_sign)
    );

    fp8_classify u_class_b (
        .op      (OP_B),
        .is_nan  (b_nan),
        .is_inf  (b_inf),
        .is_zero (b_zero),
        .sign    (b_sign)
    );

    fp_op_e       op_e;
    special_res_t res_c;
    logic         accept;
    logic         any_nan;

    logic             out_valid_q,   out_valid_d;
    logic [FP_W-1:0]  result_q,      result_d;
    logic             special_q,     special_d;
    logic             invalid_q,     invalid_d;
    logic             sticky_inv_q,  sticky_inv_d;
    logic             sticky_inf_q,  sticky_inf_d;
    logic [CNT_W-1:0] exc_count_q,   exc_count_d;

    // Handshake: a held result blocks new requests unless it drains this cycle.
    always_comb begin
        IN_READY = !out_valid_q || OUT_READY;
        accept   = IN_VALID && IN_READY;
    end

    // Special-case resolution; invalid cases take priority over inf, inf over zero.
    always_comb begin
        op_e    = fp_op_e'(FP_OPERATION);
        any_nan = a_nan || b_nan;
        res_c   = '{result: _PLUS_ZERO, special: 1'b0, invalid: 1'b0};
        unique case (op_e)
            OP_ADD: begin
                if (any_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
                    res_c = '{result: _CANON_NAN, special: 1'b1, invalid: 1'b1};
                end else if (a_inf) begin
                    res_c = '{result: OP_A, special: 1'b1, invalid: 1'b0};
                end else if (b_inf) begin
                    res_c = '{result: OP_B, special: 1'b1, invalid: 1'b0};
                end else if (a_zero && b_zero) begin
                    res_c = '{result: signed_zero(a_sign & b_sign), special: 1'b1, invalid: 1'b0};
                end else if (a_zero) begin
                    res_c = '{result: OP_B, special: 1'b1, invalid: 1'b0};
                end else if (b_zero) begin
                    res_c = '{result: OP_A, special: 1'b1, invalid: 1'b0};
                end
            end
            OP_SUB: begin
                if (any_nan || (a_inf && b_inf && (a_sign == b_sign))) begin
                    res_c = '{result: _CANON_NAN, special: 1'b1, invalid: 1'b1};
                end else if (a_inf) begin
                    res_c = '{result: OP_A, special: 1'b1, invalid: 1'b0};
                end else if (b_inf) begin
                    res_c = '{result: negate(OP_B), special: 1'b1, invalid: 1'b0};
                end else if (a_zero && b_zero) begin
                    res_c = '{result: signed_zero(a_sign & ~b_sign), special: 1'b1, invalid: 1'b0};
                end else if (a_zero) begin
                    res_c = '{result: negate(OP_B), special: 1'b1, invalid: 1'b0};
                end else if (b_zero) begin
                    res_c = '{result: OP_A, special: 1'b1, invalid: 1'b0};
                end
            end
            OP_MUL: begin
                if (any_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                    res_c = '{result: _CANON_NAN, special: 1'b1, invalid: 1'b1};
                end else if (a_inf || b_inf) begin
                    res_c = '{result: signed_inf(a_sign ^ b_sign), special: 1'b1, invalid: 1'b0};
                end else if (a_zero || b_zero) begin
                    res_c = '{result: signed_zero(a_sign ^ b_sign), special: 1'b1, invalid: 1'b0};
                end
            end
            default: begin
                res_c = '{result: _CANON_NAN, special: 1'b1, invalid: 1'b1};
            end
        endcase
    end

    // Output register next-state: load on accept, drain on consume, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        special_d   = special_q;
        invalid_d   = invalid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_c.result;
            special_d   = res_c.special;
            invalid_d   = res_c.invalid;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    // Sticky status: clear first, then apply this cycle's event so it is never lost.
    always_comb begin
        sticky_inv_d = CLR_STICKY ? 1'b0 : sticky_inv_q;
        sticky_inf_d = CLR_STICKY ? 1'b0 : sticky_inf_q;
        exc_count_d  = CLR_STICKY ? '0 : exc_count_q;
        if (accept && res_c.invalid) begin
            sticky_inv_d = 1'b1;
            if (!(&exc_count_d)) begin
                exc_count_d = exc_count_d + CNT_W'(1);
            end
        end
        if (accept && !res_c.invalid && is_inf_code(res_c.result)) begin
            sticky_inf_d = 1'b1;
        end
    end

    // State registers with synchronous reset overriding every other update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q  <= 1'b0;
            result_q     <= _PLUS_ZERO;
            special_q    <= 1'b0;
            invalid_q    <= 1'b0;
            sticky_inv_q <= 1'b0;
            sticky_inf_q <= 1'b0;
            exc_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            special_q    <= special_d;
            invalid_q    <= invalid_d;
            sticky_inv_q <= sticky_inv_d;
            sticky_inf_q <= sticky_inf_d;
            exc_count_q  <= exc_count_d;
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        OUT_VALID      = out_valid_q;
        RESULT         = result_q;
        RESULT_SPECIAL = special_q;
        EXC_INVALID    = invalid_q;
        STICKY_INVALID = sticky_inv_q;
        STICKY_INF     = sticky_inf_q;
        EXC_COUNT      = exc_count_q;
    end

endmodule

// File: tb/tb_fpu_exception_handler.sv
// Directed bench for fpu_exception_handler with a rule-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_fpu_exception_handler;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [1:0]       FP_OPERATION = 2'b00;
    logic [7:0]       OP_A = 8'h00;
    logic [7:0]       OP_B = 8'h00;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [7:0]       RESULT;
    logic             RESULT_SPECIAL;
    logic             EXC_INVALID;
    logic             STICKY_INVALID;
    logic             STICKY_INF;
    logic [CNT_W-1:0] EXC_COUNT;
    logic             CLR_STICKY = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fpu_exception_handler #(.CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IN_VALID       (IN_VALID),
        .IN_READY       (IN_READY),
        .FP_OPERATION   (FP_OPERATION),
        .OP_A           (OP_A),
        .OP_B           (OP_B),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .RESULT         (RESULT),
        .RESULT_SPECIAL (RESULT_SPECIAL),
        .EXC_INVALID    (EXC_INVALID),
        .STICKY_INVALID (STICKY_INVALID),
        .STICKY_INF     (STICKY_INF),
        .EXC_COUNT      (EXC_COUNT),
        .CLR_STICKY     (CLR_STICKY)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Returns {result[7:0], special, invalid} from the arithmetic rules.
    function automatic logic [9:0] ref_eval(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int  ea, ma, eb, mb;
        bit  sa, sb, na, nb, ia, ib, za, zb, sb_eff;
        ea = int'(a[6:3]); ma = int'(a[2:0]); sa = a[7];
        eb = int'(b[6:3]); mb = int'(b[2:0]); sb = b[7];
        na = (ea == 15) && (ma != 0); ia = (ea == 15) && (ma == 0); za = (ea == 0) && (ma == 0);
        nb = (eb == 15) && (mb != 0); ib = (eb == 15) && (mb == 0); zb = (eb == 0) && (mb == 0);
        if (op == 2'd3 || na || nb) return {8'h7C, 2'b11};
        if (op == 2'd2) begin
            if ((ia && zb) || (za && ib)) return {8'h7C, 2'b11};
            if (ia || ib) return {sa ^ sb, 7'h78, 2'b10};
            if (za || zb) return {sa ^ sb, 7'h00, 2'b10};
            return 10'd0;
        end
        // subtraction is addition of B with its sign flipped
        sb_eff = (op == 2'd1) ? !sb : sb;
        if (ia && ib) return (sa != sb_eff) ? {8'h7C, 2'b11} : {sa, 7'h78, 2'b10};
        if (ia) return {a, 2'b10};
        if (ib) return {sb_eff, 7'h78, 2'b10};
        if (za && zb) return {sa & sb_eff, 7'h00, 2'b10};
        if (za) return {sb_eff, b[6:0], 2'b10};
        if (zb) return {a, 2'b10};
        return 10'd0;
    endfunction

    bit       m_valid = 0, m_spec = 0, m_inv = 0, m_sinv = 0, m_sinf = 0;
    bit [7:0] m_res = 0;
    int       m_cnt = 0;

    always @(posedge CLK) begin
        bit       acc;
        bit [9:0] r;
        acc = IN_VALID && (!m_valid || OUT_READY);
        r   = ref_eval(FP_OPERATION, OP_A, OP_B);
        if (RST) begin
            m_valid = 0; m_res = 0; m_spec = 0; m_inv = 0;
            m_sinv = 0; m_sinf = 0; m_cnt = 0;
        end else begin
            if (CLR_STICKY) begin
                m_sinv = 0; m_sinf = 0; m_cnt = 0;
            end
            if (acc) begin
                m_valid = 1; m_res = r[9:2]; m_spec = r[1]; m_inv = r[0];
                if (r[0]) begin
                    m_sinv = 1;
                    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                end else if (r[8:2] == 7'h78) begin
                    m_sinf = 1;
                end
            end else if (OUT_READY) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_in_ready",  32'(IN_READY),       32'(!m_valid || OUT_READY));
            chk("m_out_valid", 32'(OUT_VALID),      32'(m_valid));
            chk("m_result",    32'(RESULT),         32'(m_res));
            chk("m_special",   32'(RESULT_SPECIAL), 32'(m_spec));
            chk("m_exc_inv",   32'(EXC_INVALID),    32'(m_inv));
            chk("m_st_inv",    32'(STICKY_INVALID), 32'(m_sinv));
            chk("m_st_inf",    32'(STICKY_INF),     32'(m_sinf));
            chk("m_count",     32'(EXC_COUNT),      32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit ordy, input bit clr);
        @(negedge CLK);
        #2;
        IN_VALID = v; FP_OPERATION = op; OP_A = a; OP_B = b;
        OUT_READY = ordy; CLR_STICKY = clr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        apply(1, op, a, b, 1, 0);
        step();
    endtask

    typedef struct { logic [1:0] op; logic [7:0] a; logic [7:0] b; } vec_t;
    vec_t extra[$];

    initial begin
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
        chk("rst_count",     32'(EXC_COUNT), 32'h0);
        apply(0, 2'b00, 8'h00, 8'h00, 1, 0);
        RST = 1'b0;
        #1;
        chk("rst_rel_in_ready", 32'(IN_READY), 32'h1);
        step();

        // opposite-sign infinities under add
        send(2'b00, 8'h78, 8'hF8);
        chk("add_inf_valid",  32'(OUT_VALID),      32'h1);
        chk("add_inf_result", 32'(RESULT),         32'h7C);
        chk("add_inf_exc",    32'(EXC_INVALID),    32'h1);
        chk("add_inf_sticky", 32'(STICKY_INVALID), 32'h1);
        chk("add_inf_count",  32'(EXC_COUNT),      32'h1);

        send(2'b01, 8'hF8, 8'hF8);
        chk("sub_inf_result", 32'(RESULT),      32'h7C);
        chk("sub_inf_exc",    32'(EXC_INVALID), 32'h1);

        send(2'b10, 8'h78, 8'h80);
        chk("mul_inf0_result", 32'(RESULT),      32'h7C);
        chk("mul_inf0_exc",    32'(EXC_INVALID), 32'h1);
        chk("mul_inf0_count",  32'(EXC_COUNT),   32'h3);

        // -inf * +1.0: sign is the XOR of the operand signs
        send(2'b10, 8'hF8, 8'h38);
        chk("mul_inf_result", 32'(RESULT),      32'hF8);
        chk("mul_inf_exc",    32'(EXC_INVALID), 32'h0);
        chk("mul_inf_stinf",  32'(STICKY_INF),  32'h1);

        send(2'b01, 8'h00, 8'h38);
        chk("sub_zero_result",  32'(RESULT),         32'hB8);
        chk("sub_zero_special", 32'(RESULT_SPECIAL), 32'h1);

        send(2'b00, 8'h38, 8'h40);
        chk("add_norm_special", 32'(RESULT_SPECIAL), 32'h0);
        chk("add_norm_result",  32'(RESULT),         32'h00);

        // further patterns checked only by the model
        extra = '{'{2'b00, 8'h80, 8'h80}, '{2'b01, 8'h80, 8'h00}, '{2'b00, 8'hB8, 8'h78},
                  '{2'b01, 8'h38, 8'h78}, '{2'b00, 8'h79, 8'h38}, '{2'b10, 8'hB8, 8'h80},
                  '{2'b01, 8'h78, 8'h78}, '{2'b00, 8'h78, 8'h78}, '{2'b01, 8'h40, 8'h00},
                  '{2'b10, 8'h00, 8'hF8}, '{2'b01, 8'h78, 8'hF8}, '{2'b00, 8'h00, 8'hC0}};
        foreach (extra[i]) send(extra[i].op, extra[i].a, extra[i].b);
        apply(0, 2'b00, 8'h00, 8'h00, 1, 0);
        step();

        // back-pressure: first result held while the next request waits
        send(2'b00, 8'h00, 8'h38);
        chk("bp_first_result", 32'(RESULT), 32'h38);
        for (int i = 0; i < 3; i++) begin
            apply(1, 2'b10, 8'h38, 8'h00, 0, 0);
            step();
            chk("bp_in_ready", 32'(IN_READY),       32'h0);
            chk("bp_hold_res", 32'(RESULT),         32'h38);
            chk("bp_hold_vld", 32'(OUT_VALID),      32'h1);
            chk("bp_hold_spc", 32'(RESULT_SPECIAL), 32'h1);
        end
        apply(1, 2'b10, 8'h38, 8'h00, 1, 0);
        #1;
        chk("bp_release_ready", 32'(IN_READY), 32'h1);
        step();
        chk("bp_second_result", 32'(RESULT),         32'h00);
        chk("bp_second_spc",    32'(RESULT_SPECIAL), 32'h1);
        chk("bp_second_vld",    32'(OUT_VALID),      32'h1);
        apply(0, 2'b00, 8'h00, 8'h00, 1, 0);
        step();
        chk("drain_valid", 32'(OUT_VALID), 32'h0);

        // clear coinciding with a new invalid event
        apply(1, 2'b11, 8'h38, 8'h38, 1, 1);
        step();
        chk("clr_coin_stinv", 32'(STICKY_INVALID), 32'h1);
        chk("clr_coin_count", 32'(EXC_COUNT),      32'h1);
        chk("clr_coin_stinf", 32'(STICKY_INF),     32'h0);

        // saturation of the invalid counter
        for (int i = 0; i < 300; i++) begin
            apply(1, 2'b11, 8'h11, 8'h22, 1, 0);
        end
        step();
        chk("sat_count", 32'(EXC_COUNT), 32'(CNT_MAX));

        // reset with a pending result
        apply(1, 2'b00, 8'h78, 8'hF8, 0, 0);
        step();
        chk("pre_rst_valid", 32'(OUT_VALID), 32'h1);
        apply(1, 2'b00, 8'h78, 8'hF8, 0, 1);
        RST = 1'b1;
        step();
        chk("rst_valid",   32'(OUT_VALID),      32'h0);
        chk("rst_result",  32'(RESULT),         32'h0);
        chk("rst_special", 32'(RESULT_SPECIAL), 32'h0);
        chk("rst_exc",     32'(EXC_INVALID),    32'h0);
        chk("rst_stinv",   32'(STICKY_INVALID), 32'h0);
        chk("rst_stinf",   32'(STICKY_INF),     32'h0);
        chk("rst_cnt",     32'(EXC_COUNT),      32'h0);
        apply(0, 2'b00, 8'h00, 8'h00, 0, 0);
        RST = 1'b0;
        step();
        chk("post_rst_ready", 32'(IN_READY), 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
